// File: rtl/out_min_pulse_shaper.sv
// Output pin shaper: enforces minimum high/low times and coalesces requests made during a hold window.
// Define OUT_SHAPER_STATS_EN to build the saturating toggle/drop statistics counters.
module out_min_pulse_shaper #(
    parameter int CNT_WIDTH   = 4,
    parameter int MIN_HIGH    = 4,
    parameter int MIN_LOW     = 3,
    parameter bit RESET_LEVEL = 1'b0,
    parameter int STAT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  level_i,
    output logic                  pin_o,
    output logic                  busy_o,
    output logic                  pending_o,
    output logic                  drop_o,
    output logic [STAT_WIDTH-1:0] toggle_cnt_o,
    output logic [STAT_WIDTH-1:0] drop_cnt_o
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LOAD_HIGH = CNT_WIDTH'(MIN_HIGH - 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_LOW  = CNT_WIDTH'(MIN_LOW - 1);

    state_t               r_state;
    state_t               w_stateNext;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cntNext;
    logic                 r_pin;
    logic                 w_pinNext;
    logic                 r_pendPrev;
    logic                 r_drop;
    logic                 w_dropNext;
    logic                 w_eligible;
    logic                 w_pending;
    logic                 w_toggle;

    // The hold counter is loaded with MIN-1 so the last held cycle is itself eligible.
    always_comb begin
        w_eligible  = (r_state == ST_STABLE) || (r_cnt == '0);
        w_pending   = (level_i != r_pin) && !w_eligible;
        w_toggle    = w_eligible && (level_i != r_pin);
        w_dropNext  = r_pendPrev && (level_i == r_pin) && !w_eligible;
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_pinNext   = r_pin;
        if (w_toggle) begin
            w_pinNext   = !r_pin;
            w_stateNext = ST_HOLD;
            w_cntNext   = r_pin ? LOAD_LOW : LOAD_HIGH;
        end else if (w_eligible) begin
            w_stateNext = ST_STABLE;
            w_cntNext   = '0;
        end else begin
            w_cntNext   = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_STABLE;
            r_cnt      <= '0;
            r_pin      <= RESET_LEVEL;
            r_pendPrev <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_pin      <= w_pinNext;
            r_pendPrev <= w_pending;
            r_drop     <= w_dropNext;
        end
    end

    assign pin_o     = r_pin;
    assign busy_o    = (r_state == ST_HOLD) && (r_cnt != '0);
    assign pending_o = w_pending;
    assign drop_o    = r_drop;

`ifdef OUT_SHAPER_STATS_EN
    logic [STAT_WIDTH-1:0] r_togCnt;
    logic [STAT_WIDTH-1:0] r_dropCnt;

    // Both statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_togCnt  <= '0;
            r_dropCnt <= '0;
        end else begin
            if (w_toggle && (r_togCnt != '1)) begin
                r_togCnt <= r_togCnt + 1'b1;
            end
            if (w_dropNext && (r_dropCnt != '1)) begin
                r_dropCnt <= r_dropCnt + 1'b1;
            end
        end
    end

    assign toggle_cnt_o = r_togCnt;
    assign drop_cnt_o   = r_dropCnt;
`else
    assign toggle_cnt_o = '0;
    assign drop_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_out_min_pulse_shaper.sv
// Randomized self-checking bench for out_min_pulse_shaper using a timestamp-based reference model.
// Three instances run in lockstep: default timing, MIN_HIGH=MIN_LOW=1, and STAT_WIDTH=2.
module tb_out_min_pulse_shaper;

`ifdef OUT_SHAPER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] levelV;
    logic [2:0] pinV;
    logic [2:0] busyV;
    logic [2:0] pendV;
    logic [2:0] dropV;
    logic [7:0] togA;
    logic [7:0] drpA;
    logic [7:0] togB;
    logic [7:0] drpB;
    logic [1:0] togC;
    logic [1:0] drpC;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int minH[3]   = '{4, 1, 4};
    int minL[3]   = '{3, 1, 3};
    int satMax[3] = '{255, 255, 3};

    bit mPin[3];
    int mLastT[3];
    bit mPrevPend[3];
    bit mDrop[3];
    int mTog[3];
    int mDrp[3];

    bit monitorOn = 1'b0;
    bit logRuns = 1'b0;
    int dropSeen = 0;
    int fallSeen = 0;
    bit prevObsPin = 1'b0;
    bit runLog[$];

    always #5 clock = ~clock;

    out_min_pulse_shaper dut (
        .clk_i(clock), .rst_i(reset), .level_i(levelV[0]),
        .pin_o(pinV[0]), .busy_o(busyV[0]), .pending_o(pendV[0]), .drop_o(dropV[0]),
        .toggle_cnt_o(togA), .drop_cnt_o(drpA)
    );

    out_min_pulse_shaper #(.MIN_HIGH(1), .MIN_LOW(1)) dutMin1 (
        .clk_i(clock), .rst_i(reset), .level_i(levelV[1]),
        .pin_o(pinV[1]), .busy_o(busyV[1]), .pending_o(pendV[1]), .drop_o(dropV[1]),
        .toggle_cnt_o(togB), .drop_cnt_o(drpB)
    );

    out_min_pulse_shaper #(.STAT_WIDTH(2)) dutSat (
        .clk_i(clock), .rst_i(reset), .level_i(levelV[2]),
        .pin_o(pinV[2]), .busy_o(busyV[2]), .pending_o(pendV[2]), .drop_o(dropV[2]),
        .toggle_cnt_o(togC), .drop_cnt_o(drpC)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int getTog(input int i);
        case (i)
            0:       return int'(togA);
            1:       return int'(togB);
            default: return int'(togC);
        endcase
    endfunction

    function automatic int getDrp(input int i);
        case (i)
            0:       return int'(drpA);
            1:       return int'(drpB);
            default: return int'(drpC);
        endcase
    endfunction

    // A toggle is permitted once MIN-1 cycles have elapsed since the pin last changed.
    function automatic bit modelEligible(input int i);
        int need;
        need = mPin[i] ? minH[i] : minL[i];
        return (cyc - mLastT[i]) >= (need - 1);
    endfunction

    task automatic resetModels();
        for (int i = 0; i < 3; i++) begin
            mPin[i]      = 1'b0;
            mLastT[i]    = -1000;
            mPrevPend[i] = 1'b0;
            mDrop[i]     = 1'b0;
            mTog[i]      = 0;
            mDrp[i]      = 0;
        end
    endtask

    task automatic modelAdvance(input int i, input bit lvl);
        bit elig;
        bit pend;
        bit nextDrop;
        elig     = modelEligible(i);
        pend     = (lvl != mPin[i]) && !elig;
        nextDrop = mPrevPend[i] && (lvl == mPin[i]) && !elig;
        if (elig && (lvl != mPin[i])) begin
            mPin[i]   = lvl;
            mLastT[i] = cyc + 1;
            if (mTog[i] < satMax[i]) mTog[i]++;
        end
        mDrop[i] = nextDrop;
        if (nextDrop && (mDrp[i] < satMax[i])) mDrp[i]++;
        mPrevPend[i] = pend;
    endtask

    task automatic checkRegs(input int i);
        checkOutput($sformatf("pin%0d", i), int'(pinV[i]), int'(mPin[i]));
        checkOutput($sformatf("busy%0d", i), int'(busyV[i]), int'(!modelEligible(i)));
        checkOutput($sformatf("drop%0d", i), int'(dropV[i]), int'(mDrop[i]));
        checkOutput($sformatf("togCnt%0d", i), getTog(i), STATS_ON ? mTog[i] : 0);
        checkOutput($sformatf("dropCnt%0d", i), getDrp(i), STATS_ON ? mDrp[i] : 0);
    endtask

    // One clock cycle: check registered outputs, drive the new level/reset, check pending, step the model.
    task automatic applyStimulus(input bit lvl, input bit rstVal);
        @(negedge clock);
        for (int i = 0; i < 3; i++) checkRegs(i);
        if (monitorOn) begin
            if (dropV[0]) dropSeen++;
            if (prevObsPin && !pinV[0]) fallSeen++;
        end
        prevObsPin = pinV[0];
        if (logRuns) runLog.push_back(pinV[0]);
        levelV = {3{lvl}};
        reset  = rstVal;
        if (rstVal) resetModels();
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rstVal) checkRegs(i);
            checkOutput($sformatf("pending%0d", i), int'(pendV[i]),
                        int'((lvl != mPin[i]) && !modelEligible(i)));
        end
        if (!rstVal) begin
            for (int i = 0; i < 3; i++) modelAdvance(i, lvl);
            cyc++;
        end
    endtask

    task automatic checkRunLengths();
        int lens[$];
        bit vals[$];
        int len;
        len = 1;
        for (int k = 1; k < runLog.size(); k++) begin
            if (runLog[k] == runLog[k-1]) begin
                len++;
            end else begin
                lens.push_back(len);
                vals.push_back(runLog[k-1]);
                len = 1;
            end
        end
        for (int k = 1; k < lens.size(); k++) begin
            if (vals[k]) checkOutput($sformatf("runHigh len=%0d", lens[k]), int'(lens[k] >= 4 && lens[k] <= 5), 1);
            else         checkOutput($sformatf("runLow len=%0d", lens[k]), int'(lens[k] >= 3 && lens[k] <= 4), 1);
        end
        checkOutput("runCount", int'(lens.size() >= 6), 1);
        runLog.delete();
    endtask

    initial begin
        bit lvl;
        reset  = 1'b1;
        levelV = '1;
        resetModels();

        // Reset held with level high, then released: pin rises one edge later.
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0);

        // Short low request inside a high hold window must be withdrawn, not applied.
        repeat (5) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        monitorOn = 1'b1;
        dropSeen  = 0;
        fallSeen  = 0;
        applyStimulus(1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0);
        monitorOn = 1'b0;
        checkOutput("shortDrops", dropSeen, 1);
        checkOutput("shortFalls", fallSeen, 0);

        // Level toggling every cycle exercises the minimum widths.
        logRuns = 1'b1;
        for (int k = 0; k < 40; k++) applyStimulus(k[0], 1'b0);
        logRuns = 1'b0;
        checkRunLengths();

        // Random levels with mixed flip rates.
        lvl = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, (k < 100) ? 1 : 3) == 0) lvl = ~lvl;
            applyStimulus(lvl, 1'b0);
        end

        // Reset asserted two cycles into a high hold.
        repeat (6) applyStimulus(1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midResetPin", int'(pinV[0]), 0);
        checkOutput("midResetBusy", int'(busyV[0]), 0);
        applyStimulus(1'b1, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0);

        // More toggling after reset so the 2-bit counters saturate again.
        for (int k = 0; k < 30; k++) applyStimulus(~k[0], 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_min_pulse_shaper.md
Name: out_min_pulse_shaper

Overview:
- Outbound counterpart to the input synchronize-and-filter path: takes a clean internal level and drives an external pin, such as a range relay, LED or mux select.
- Guarantees a minimum high time and a minimum low time on the pin.
- Coalesces requests that arrive during a hold window; the last requested value wins.
- Sits between the digital_top control logic and the output pad.

Parameters:
- CNT_WIDTH, 4: width of the hold counter.
- MIN_HIGH, 4: minimum cycles pin_o stays high after rising; range 1..2^CNT_WIDTH.
- MIN_LOW, 3: minimum cycles pin_o stays low after falling; range 1..2^CNT_WIDTH.
- RESET_LEVEL, 0: value of pin_o during and after reset.
- STAT_WIDTH, 8: width of the statistics counters.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- level_i  input  1  requested output level, synchronous to clk_i
- pin_o  output  1  shaped output to pad; registered, no combinational path from level_i
- busy_o  output  1  high while a hold window is running
- pending_o  output  1  high when level_i != pin_o but a toggle is not yet permitted
- drop_o  output  1  one-cycle pulse when a pending request is withdrawn before being applied
- toggle_cnt_o  output  STAT_WIDTH  saturating count of pin_o transitions
- drop_cnt_o  output  STAT_WIDTH  saturating count of drop_o pulses

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-hold):
  - pin_o = RESET_LEVEL.
  - State STABLE, hold counter = 0.
  - busy_o, pending_o, drop_o = 0.
  - Both statistics counters = 0.
- States:
  - STABLE: toggle permitted.
  - HOLD: hold counter running.
- Eligibility: a cycle is eligible when state == STABLE, or state == HOLD with counter == 0.
- Eligible cycle with level_i != pin_o:
  - pin_o inverts at the next edge (latency 1 cycle from level_i change).
  - State goes to HOLD.
  - Counter loads (MIN_HIGH-1) if the new pin_o is 1, else (MIN_LOW-1).
- Eligible cycle with level_i == pin_o: state goes to STABLE, counter stays 0.
- HOLD with counter != 0: counter decrements by 1 per cycle; pin_o is held regardless of level_i.
- Resulting timing:
  - After a toggle at edge T, pin_o holds for at least MIN_x cycles.
  - The earliest next toggle is at edge T+MIN_x.
  - MIN_x = 1 permits a toggle every cycle.
- busy_o = (state == HOLD) && (counter != 0); registered-state derived, combinational output allowed.
- pending_o = (level_i != pin_o) && !eligible; combinational.
- drop_o:
  - Registered.
  - Pulses for one cycle at the edge after a cycle where pending_o was 1 and level_i now equals pin_o while still not eligible.
  - Multiple bounces within one window each produce a pulse.
  - Toggles are never queued: only the final level_i at the eligible cycle matters.
- Counter arithmetic:
  - Unsigned CNT_WIDTH bits.
  - No decrement below 0; no wrap.
- Statistics counters: increment by 1 per event and saturate at 2^STAT_WIDTH-1. No wrap.
- Simultaneous events: a level_i change in the same cycle the counter reaches 0 is treated as eligible on the following cycle (counter == 0 is evaluated from registered state).

Optional Feature:
- Macro: OUT_SHAPER_STATS_EN.
- Defined: toggle_cnt_o and drop_cnt_o count as specified in Behaviour.
- Undefined:
  - Counters are not instantiated.
  - Both ports are driven constant 0.
  - drop_o is still generated.
  - All other behaviour is identical.

Test Plan (MIN_HIGH=4, MIN_LOW=3, RESET_LEVEL=0 unless noted):
- Reset and first toggle: hold rst_i 3 cycles with level_i=1, then release.
  - Required: pin_o=0 during reset; pin_o=1 one edge after the first sampled clock.
  - Required: busy_o high for exactly 3 cycles; toggle_cnt_o=1.
- Short low request: raise pin_o, drop level_i 1 cycle after the rise, restore it 1 cycle later.
  - Required: pin_o never falls; one drop_o pulse; drop_cnt_o=1.
- Minimum widths: level_i toggles every cycle for 40 cycles.
  - Required: every high run of pin_o is >= 4 cycles and every low run is >= 3 cycles; no run exceeds its minimum by more than 1 cycle.
- Boundary MIN=1: MIN_HIGH=MIN_LOW=1, level_i toggles every cycle.
  - Required: pin_o follows level_i delayed by 1 cycle.
  - Required: busy_o stays 0 and drop_o never pulses.
- Reset mid-hold: assert rst_i 2 cycles into a high hold.
  - Required: pin_o=0 immediately (asynchronous); busy_o=0; counters cleared.
  - Required after release with level_i=1: pin_o=1 after 1 edge.
- Saturation (STAT_WIDTH=2, macro defined): 6 toggles.
  - Required: toggle_cnt_o reads 3 and holds at 3.
  - Required with macro undefined: toggle_cnt_o and drop_cnt_o read 0 throughout.
